thread_lsu: RTL and testbench
=============================

Name: thread_lsu

Overview:
- Per-thread load/store unit; one instance per thread, alongside that thread's register file.
- Consumes the register file's two read ports: rs = address, rt = store data.
- Performs one LDR or STR per instruction against the shared memory controller via valid/ready handshakes.
- Returns loaded data on lsu_out, which the writeback mux steers into R0-R12.

Parameters:
ADDR_BITS, 8, memory address width (rs width)
DATA_BITS, 8, data width (rt, lsu_out, memory data)
TIMEOUT_CYCLES, 64, max cycles in WAITING before abort; 0 disables the timeout

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  thread active in current block; 0 forces IDLE
core_state  input  3  core pipeline phase (core_state_t)
mem_read_enable  input  1  decoded LDR
mem_write_enable  input  1  decoded STR
rs  input  ADDR_BITS  address operand (register file read_data1)
rt  input  DATA_BITS  store data (register file read_data2)
mem_read_valid  output  1  read request to memory controller
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  read data returned this cycle
mem_read_data  input  DATA_BITS  returned data
mem_write_valid  output  1  write request
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  write accepted this cycle
lsu_state  output  2  lsu_state_t, polled by scheduler to leave WAIT
lsu_out  output  DATA_BITS  last loaded value
lsu_error  output  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: lsu_state=IDLE, all valids 0, addresses/data 0, lsu_out 0, lsu_error 0, timeout counter 0. Reset asserted mid-transaction drops valids at that same edge; no request is retained.
- Core state encodings: FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6.
- LSU state encodings: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- IDLE -> REQUESTING when enable and core_state==REQUEST and (mem_read_enable or mem_write_enable).
  - rs and rt are captured into the address/data output registers at this edge.
  - The operation type is latched: read has priority if both enables are set; the write is dropped.
- REQUESTING -> WAITING after 1 cycle. The matching valid asserts on entry to WAITING.
- WAITING: valid held with stable address/data until the matching ready is seen.
  - Read: on mem_read_ready, lsu_out <= mem_read_data, valid drops next edge, -> DONE.
  - Write: on mem_write_ready, valid drops, -> DONE.
  - Ready seen while no request is outstanding is ignored.
- Timeout: counter increments each WAITING cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES (nonzero): valid drops, lsu_error <= 1, lsu_out unchanged, -> DONE.
  - The counter clears on leaving WAITING.
  - Ready arriving in the same cycle as expiry wins; no error is flagged.
- DONE -> IDLE when core_state==UPDATE. lsu_out holds its value until the next completed load.
- Latency: valid first high 2 cycles after the REQUEST edge. Minimum load = 3 cycles REQUEST-to-DONE with a same-cycle ready.
- enable=0: stays IDLE and never asserts valid. If enable drops mid-transaction, the transaction completes anyway so memory is not left with a dangling handshake.
- Address and data are fixed width; no wrap or extension logic. rs=0xFF is a valid address.
- lsu_error clears only on reset.

Decomposition:
- Shared package gpu_pkg: core_state_t enum (3-bit), lsu_state_t enum (2-bit), default ADDR_BITS/DATA_BITS constants. The scheduler and register-file writeback mux import the same package.
- No sub-module: FSM, counter and output registers fit in one module (~150-200 lines).

Test Plan:
- Load: rs=0x20, LDR, core_state REQUEST; memory ready 2 cycles after valid with data 0xA5 -> mem_read_address=0x20, lsu_out=0xA5, lsu_state DONE, then IDLE on UPDATE.
- Store: rs=0x07, rt=0x3C, STR; same-cycle ready -> one write of 0x3C to 0x07, valid high exactly 1 cycle, lsu_out unchanged.
- Both enables set with rs=0x10 -> only a read issued, mem_write_valid never high.
- TIMEOUT_CYCLES=4, no ready -> valid drops after 4 WAITING cycles, lsu_error=1, lsu_out holds the prior 0xA5. A following load still succeeds and lsu_error stays 1.
- Reset pulse while WAITING on a read -> next edge: valid 0, lsu_state IDLE, lsu_out 0. A late mem_read_ready is ignored.
- enable=0 with LDR in REQUEST -> lsu_state stays IDLE, no valid for 10 cycles.

Source files
------------

// File: rtl/gpu_pkg.sv
// Types and defaults shared by the scheduler, register-file writeback mux and
// per-thread load/store units.
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: one LDR or STR per instruction against the
// shared memory controller, with a sticky timeout flag for hung requests.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS      = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [ADDR_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam logic [1:0] S_IDLE       = LSU_IDLE;
    localparam logic [1:0] S_REQUESTING = LSU_REQUESTING;
    localparam logic [1:0] S_WAITING    = LSU_WAITING;
    localparam logic [1:0] S_DONE       = LSU_DONE;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]           state_q,  state_d;
    logic                 is_read_q, is_read_d;
    logic                 rvalid_q, rvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic [ADDR_BITS-1:0] addr_q,   addr_d;
    logic [DATA_BITS-1:0] wdata_q,  wdata_d;
    logic [DATA_BITS-1:0] out_q,    out_d;
    logic                 err_q,    err_d;
    logic [CW-1:0]        cnt_q,    cnt_d;

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        rvalid_d  = rvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        out_d     = out_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Read wins when both enables are decoded; the write is dropped.
                if (enable && core_state == CORE_REQUEST &&
                    (mem_read_enable || mem_write_enable)) begin
                    state_d   = S_REQUESTING;
                    addr_d    = rs;
                    wdata_d   = rt;
                    is_read_d = mem_read_enable;
                end
            end
            S_REQUESTING: begin
                state_d  = S_WAITING;
                rvalid_d = is_read_q;
                wvalid_d = !is_read_q;
                cnt_d    = '0;
            end
            S_WAITING: begin
                // Ready takes precedence over a timeout expiring in the same cycle.
                if (is_read_q && mem_read_ready) begin
                    out_d    = mem_read_data;
                    rvalid_d = 1'b0;
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end else if (!is_read_q && mem_write_ready) begin
                    wvalid_d = 1'b0;
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (core_state == CORE_UPDATE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            is_read_q <= 1'b0;
            rvalid_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            rvalid_q  <= rvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            out_q     <= out_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_read_valid    = rvalid_q;
    assign mem_read_address  = addr_q;
    assign mem_write_valid   = wvalid_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = wdata_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;
    assign lsu_error         = err_q;

endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu with a short timeout so expiry is reachable.
module tb_thread_lsu;

    localparam logic [2:0] C_REQ = 3'd3;
    localparam logic [2:0] C_WAIT = 3'd4;
    localparam logic [2:0] C_EXEC = 3'd5;
    localparam logic [2:0] C_UPD = 3'd6;

    logic       clk = 1'b0;
    logic       reset, enable, rd_en, wr_en, rready, wready;
    logic [2:0] core_state;
    logic [7:0] rs, rt, rdata;
    logic       rvalid, wvalid, err;
    logic [7:0] raddr, waddr, wdata, out;
    logic [1:0] st;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(rd_en), .mem_write_enable(wr_en), .rs(rs), .rt(rt),
        .mem_read_valid(rvalid), .mem_read_address(raddr),
        .mem_read_ready(rready), .mem_read_data(rdata),
        .mem_write_valid(wvalid), .mem_write_address(waddr),
        .mem_write_data(wdata), .mem_write_ready(wready),
        .lsu_state(st), .lsu_out(out), .lsu_error(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        rs = a; rt = d; rd_en = rd; wr_en = wr; core_state = C_REQ;
        tick();
        rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00; core_state = C_WAIT;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++;
        if ({st, rvalid, wvalid, raddr, wdata, out, err} !== 29'd0)
            $display("FAIL reset: state=%0d rv=%b wv=%b addr=%h wd=%h out=%h err=%b want all 0",
                     st, rvalid, wvalid, raddr, wdata, out, err);
        else passed++;
    endtask

    task automatic test_load;
        issue(1'b1, 1'b0, 8'h20, 8'h55);
        total++;
        if (st !== 2'd1 || rvalid !== 1'b0) $display("FAIL load_req: state=%0d rv=%b want 1/0", st, rvalid);
        else passed++;
        tick();
        total++;
        if (st !== 2'd2 || rvalid !== 1'b1 || raddr !== 8'h20)
            $display("FAIL load_valid: state=%0d rv=%b addr=%h want 2/1/20", st, rvalid, raddr);
        else passed++;
        tick();
        rready = 1'b1; rdata = 8'hA5;
        tick();
        rready = 1'b0; rdata = 8'h00;
        total++;
        if (st !== 2'd3 || rvalid !== 1'b0 || out !== 8'hA5)
            $display("FAIL load_done: state=%0d rv=%b out=%h want 3/0/a5", st, rvalid, out);
        else passed++;
        core_state = C_EXEC;
        tick();
        total++;
        if (st !== 2'd3) $display("FAIL load_hold_done: state=%0d want 3", st);
        else passed++;
        core_state = C_UPD;
        tick();
        total++;
        if (st !== 2'd0 || out !== 8'hA5) $display("FAIL load_update: state=%0d out=%h want 0/a5", st, out);
        else passed++;
    endtask

    task automatic test_store;
        issue(1'b0, 1'b1, 8'h07, 8'h3C);
        tick();
        total++;
        if (wvalid !== 1'b1 || rvalid !== 1'b0 || waddr !== 8'h07 || wdata !== 8'h3C)
            $display("FAIL store_valid: wv=%b rv=%b addr=%h data=%h want 1/0/07/3c", wvalid, rvalid, waddr, wdata);
        else passed++;
        wready = 1'b1;
        tick();
        wready = 1'b0;
        total++;
        if (wvalid !== 1'b0 || st !== 2'd3 || out !== 8'hA5)
            $display("FAIL store_done: wv=%b state=%0d out=%h want 0/3/a5", wvalid, st, out);
        else passed++;
        core_state = C_UPD;
        tick();
        total++;
        if (st !== 2'd0) $display("FAIL store_update: state=%0d want 0", st);
        else passed++;
    endtask

    task automatic test_timeout;
        issue(1'b1, 1'b0, 8'h40, 8'h00);
        tick(); tick(); tick(); tick();
        total++;
        if (rvalid !== 1'b1 || err !== 1'b0 || st !== 2'd2)
            $display("FAIL timeout_pending: rv=%b err=%b state=%0d want 1/0/2", rvalid, err, st);
        else passed++;
        tick();
        total++;
        if (rvalid !== 1'b0 || err !== 1'b1 || st !== 2'd3 || out !== 8'hA5)
            $display("FAIL timeout_expire: rv=%b err=%b state=%0d out=%h want 0/1/3/a5", rvalid, err, st, out);
        else passed++;
        core_state = C_UPD;
        tick();
        issue(1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        rready = 1'b1; rdata = 8'h66;
        tick();
        rready = 1'b0;
        total++;
        if (st !== 2'd3 || out !== 8'h66 || err !== 1'b1)
            $display("FAIL load_after_timeout: state=%0d out=%h err=%b want 3/66/1", st, out, err);
        else passed++;
        core_state = C_UPD;
        tick();
    endtask

    task automatic test_both_enables;
        logic saw_w;
        saw_w = 1'b0;
        issue(1'b1, 1'b1, 8'h10, 8'hEE);
        saw_w |= wvalid;
        tick();
        saw_w |= wvalid;
        total++;
        if (rvalid !== 1'b1 || raddr !== 8'h10)
            $display("FAIL both_read: rv=%b addr=%h want 1/10", rvalid, raddr);
        else passed++;
        wready = 1'b1;
        tick();
        saw_w |= wvalid;
        wready = 1'b0;
        total++;
        if (st !== 2'd2 || rvalid !== 1'b1)
            $display("FAIL both_ignore_wready: state=%0d rv=%b want 2/1", st, rvalid);
        else passed++;
        rready = 1'b1; rdata = 8'h77;
        tick();
        saw_w |= wvalid;
        rready = 1'b0;
        core_state = C_UPD;
        tick();
        saw_w |= wvalid;
        total++;
        if (saw_w !== 1'b0 || out !== 8'h77)
            $display("FAIL both_no_write: saw_wvalid=%b out=%h want 0/77", saw_w, out);
        else passed++;
    endtask

    task automatic test_max_addr;
        issue(1'b1, 1'b0, 8'hFF, 8'h00);
        tick();
        rready = 1'b1; rdata = 8'h3E;
        total++;
        if (raddr !== 8'hFF) $display("FAIL max_addr: addr=%h want ff", raddr);
        else passed++;
        tick();
        rready = 1'b0;
        total++;
        if (st !== 2'd3 || out !== 8'h3E || rvalid !== 1'b0)
            $display("FAIL min_latency: state=%0d out=%h rv=%b want 3/3e/0", st, out, rvalid);
        else passed++;
        core_state = C_UPD;
        tick();
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b0, 8'h50, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (rvalid !== 1'b0 || st !== 2'd0 || out !== 8'h00 || err !== 1'b0)
            $display("FAIL reset_mid: rv=%b state=%0d out=%h err=%b want 0/0/00/0", rvalid, st, out, err);
        else passed++;
        core_state = C_WAIT;
        rready = 1'b1; rdata = 8'h99;
        tick();
        rready = 1'b0;
        total++;
        if (st !== 2'd0 || out !== 8'h00 || rvalid !== 1'b0)
            $display("FAIL late_ready: state=%0d out=%h rv=%b want 0/00/0", st, out, rvalid);
        else passed++;
    endtask

    task automatic test_disabled;
        int bad;
        bad = 0;
        enable = 1'b0; core_state = C_REQ; rd_en = 1'b1; rs = 8'h22;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (st !== 2'd0 || rvalid !== 1'b0 || wvalid !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL disabled: %0d bad cycles (state=%0d rv=%b) want 0", bad, st, rvalid);
        else passed++;
        rd_en = 1'b0; enable = 1'b1; core_state = C_WAIT;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        rready = 1'b0; wready = 1'b0; core_state = C_WAIT;
        rs = 8'h00; rt = 8'h00; rdata = 8'h00;
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_both_enables();
        test_max_addr();
        test_reset_mid();
        test_disabled();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
